// File: rtl/lnrv_icb_splt.sv
// 1-master to N-slave ICB splitter: decodes the command address to a slave port and
// returns responses in command order. Optional decode-error target: LNRV_ICB_SPLT_DEC_ERR_EN.
module lnrv_icb_splt #(
  parameter int P_ADDR_WIDTH = 32,
  parameter int P_DATA_WIDTH = 32,
  parameter int P_ICB_COUNT  = 4,
  parameter int P_OTS_COUNT  = 2,
  parameter logic [P_ICB_COUNT*P_ADDR_WIDTH-1:0] P_BASE_ADDR = '0,
  parameter logic [P_ICB_COUNT*P_ADDR_WIDTH-1:0] P_ADDR_MASK = '0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  m_icb_cmd_vld,
  output logic                                  m_icb_cmd_rdy,
  input  logic                                  m_icb_cmd_write,
  input  logic [P_ADDR_WIDTH-1:0]               m_icb_cmd_addr,
  input  logic [P_DATA_WIDTH-1:0]               m_icb_cmd_wdata,
  input  logic [P_DATA_WIDTH/8-1:0]             m_icb_cmd_wstrb,
  output logic                                  m_icb_rsp_vld,
  input  logic                                  m_icb_rsp_rdy,
  output logic [P_DATA_WIDTH-1:0]               m_icb_rsp_rdata,
  output logic                                  m_icb_rsp_err,
  output logic [P_ICB_COUNT-1:0]                sn_icb_cmd_vld,
  input  logic [P_ICB_COUNT-1:0]                sn_icb_cmd_rdy,
  output logic [P_ICB_COUNT-1:0]                sn_icb_cmd_write,
  output logic [P_ICB_COUNT*P_ADDR_WIDTH-1:0]   sn_icb_cmd_addr,
  output logic [P_ICB_COUNT*P_DATA_WIDTH-1:0]   sn_icb_cmd_wdata,
  output logic [P_ICB_COUNT*P_DATA_WIDTH/8-1:0] sn_icb_cmd_wstrb,
  input  logic [P_ICB_COUNT-1:0]                sn_icb_rsp_vld,
  output logic [P_ICB_COUNT-1:0]                sn_icb_rsp_rdy,
  input  logic [P_ICB_COUNT*P_DATA_WIDTH-1:0]   sn_icb_rsp_rdata,
  input  logic [P_ICB_COUNT-1:0]                sn_icb_rsp_err
);

  // Handshake: a transfer happens on any cycle where vld & rdy are both high at the
  // rising clock edge; vld never waits on rdy, payload is held stable while vld & !rdy.

  localparam int ID_W  = $clog2(P_ICB_COUNT + 1);
  localparam int PTR_W = (P_OTS_COUNT > 1) ? $clog2(P_OTS_COUNT) : 1;
  localparam int CNT_W = $clog2(P_OTS_COUNT + 1);
  localparam logic [ID_W-1:0] ERR_ID = ID_W'(P_ICB_COUNT);

  logic [P_ICB_COUNT-1:0] hit;
  logic [ID_W-1:0]        sel;
  logic                   sel_is_err;
  logic                   sel_rdy;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic [ID_W-1:0]        head;

  logic [ID_W-1:0]        id_mem [P_OTS_COUNT];
  logic [PTR_W-1:0]       wptr;
  logic [PTR_W-1:0]       rptr;
  logic [CNT_W-1:0]       cnt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(P_OTS_COUNT - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Address decode; the first matching window in index order wins.
  always_comb begin
    for (int i = 0; i < P_ICB_COUNT; i++) begin
      hit[i] = ((m_icb_cmd_addr ^ P_BASE_ADDR[i*P_ADDR_WIDTH +: P_ADDR_WIDTH])
                & P_ADDR_MASK[i*P_ADDR_WIDTH +: P_ADDR_WIDTH]) == '0;
    end
  end

  always_comb begin
`ifdef LNRV_ICB_SPLT_DEC_ERR_EN
    sel = ERR_ID;
`else
    sel = ID_W'(P_ICB_COUNT - 1);
`endif
    for (int i = P_ICB_COUNT - 1; i >= 0; i--) begin
      if (hit[i]) sel = ID_W'(i);
    end
  end

  assign sel_is_err = (sel == ERR_ID);

  always_comb begin
    sel_rdy = sel_is_err;
    for (int i = 0; i < P_ICB_COUNT; i++) begin
      if (sel == ID_W'(i)) sel_rdy = sn_icb_cmd_rdy[i];
    end
  end

  assign fifo_full     = (cnt == CNT_W'(P_OTS_COUNT));
  assign fifo_empty    = (cnt == '0);
  assign m_icb_cmd_rdy = !fifo_full && sel_rdy;

  always_comb begin
    for (int i = 0; i < P_ICB_COUNT; i++) begin
      sn_icb_cmd_vld[i] = m_icb_cmd_vld && !fifo_full && (sel == ID_W'(i));
    end
  end

  // Payload goes to every port; only the selected one sees vld.
  assign sn_icb_cmd_write = {P_ICB_COUNT{m_icb_cmd_write}};
  assign sn_icb_cmd_addr  = {P_ICB_COUNT{m_icb_cmd_addr}};
  assign sn_icb_cmd_wdata = {P_ICB_COUNT{m_icb_cmd_wdata}};
  assign sn_icb_cmd_wstrb = {P_ICB_COUNT{m_icb_cmd_wstrb}};

  assign push = m_icb_cmd_vld && m_icb_cmd_rdy;
  assign pop  = m_icb_rsp_vld && m_icb_rsp_rdy;
  assign head = id_mem[rptr];

  // Outstanding target-ID FIFO; a pop never frees a slot for a push in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      if (push && !pop)      cnt <= cnt + CNT_W'(1);
      else if (pop && !push) cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) id_mem[wptr] <= sel;
  end

  // Only the head slave is connected back to the master, which keeps responses in order.
  always_comb begin
    m_icb_rsp_vld   = 1'b0;
    m_icb_rsp_rdata = '0;
    m_icb_rsp_err   = 1'b0;
    sn_icb_rsp_rdy  = '0;
    if (!fifo_empty) begin
`ifdef LNRV_ICB_SPLT_DEC_ERR_EN
      if (head == ERR_ID) begin
        m_icb_rsp_vld = 1'b1;
        m_icb_rsp_err = 1'b1;
      end
`endif
      for (int i = 0; i < P_ICB_COUNT; i++) begin
        if (head == ID_W'(i)) begin
          m_icb_rsp_vld     = sn_icb_rsp_vld[i];
          sn_icb_rsp_rdy[i] = m_icb_rsp_rdy;
          if (sn_icb_rsp_vld[i]) begin
            m_icb_rsp_rdata = sn_icb_rsp_rdata[i*P_DATA_WIDTH +: P_DATA_WIDTH];
            m_icb_rsp_err   = sn_icb_rsp_err[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lnrv_icb_splt.sv
// Bench for lnrv_icb_splt: directed scenarios plus randomized traffic, checked every
// cycle against an ordered queue model of outstanding commands.
module tb_lnrv_icb_splt;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int OTS = 2;
  localparam logic [2:0] ERR_ID = 3'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            m_vld = 1'b0;
  logic            m_cmd_rdy;
  logic            m_write = 1'b0;
  logic [AW-1:0]   m_addr = '0;
  logic [DW-1:0]   m_wdata = '0;
  logic [SW-1:0]   m_wstrb = '0;
  logic            m_rsp_vld;
  logic            m_rsp_rdy = 1'b0;
  logic [DW-1:0]   m_rsp_rdata;
  logic            m_rsp_err;
  logic [N-1:0]    sn_cmd_vld;
  logic [N-1:0]    sn_cmd_rdy = '0;
  logic [N-1:0]    sn_cmd_write;
  logic [N*AW-1:0] sn_cmd_addr;
  logic [N*DW-1:0] sn_cmd_wdata;
  logic [N*SW-1:0] sn_cmd_wstrb;
  logic [N-1:0]    sn_rsp_vld = '0;
  logic [N-1:0]    sn_rsp_rdy;
  logic [N*DW-1:0] sn_rsp_rdata = '0;
  logic [N-1:0]    sn_rsp_err = '0;

  lnrv_icb_splt #(
    .P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_ICB_COUNT(N), .P_OTS_COUNT(OTS),
    .P_BASE_ADDR({32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .P_ADDR_MASK({32'hE000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000})
  ) dut (
    .clk(clk), .reset(rst),
    .m_icb_cmd_vld(m_vld), .m_icb_cmd_rdy(m_cmd_rdy), .m_icb_cmd_write(m_write),
    .m_icb_cmd_addr(m_addr), .m_icb_cmd_wdata(m_wdata), .m_icb_cmd_wstrb(m_wstrb),
    .m_icb_rsp_vld(m_rsp_vld), .m_icb_rsp_rdy(m_rsp_rdy), .m_icb_rsp_rdata(m_rsp_rdata),
    .m_icb_rsp_err(m_rsp_err),
    .sn_icb_cmd_vld(sn_cmd_vld), .sn_icb_cmd_rdy(sn_cmd_rdy), .sn_icb_cmd_write(sn_cmd_write),
    .sn_icb_cmd_addr(sn_cmd_addr), .sn_icb_cmd_wdata(sn_cmd_wdata), .sn_icb_cmd_wstrb(sn_cmd_wstrb),
    .sn_icb_rsp_vld(sn_rsp_vld), .sn_icb_rsp_rdy(sn_rsp_rdy), .sn_icb_rsp_rdata(sn_rsp_rdata),
    .sn_icb_rsp_err(sn_rsp_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Windows: s0 0x0xxxxxxx, s1 0x1xxxxxxx, s2 0x2xxxxxxx, s3 0x2/0x3xxxxxxx (s2 wins on overlap).
  function automatic logic [31:0] base_of(input int i);
    case (i)
      0: return 32'h0000_0000;
      1: return 32'h1000_0000;
      default: return 32'h2000_0000;
    endcase
  endfunction

  function automatic logic [31:0] mask_of(input int i);
    return (i == 3) ? 32'hE000_0000 : 32'hF000_0000;
  endfunction

  function automatic logic [2:0] decode(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if (((a ^ base_of(i)) & mask_of(i)) == 32'h0) return 3'(i);
`ifdef LNRV_ICB_SPLT_DEC_ERR_EN
    return ERR_ID;
`else
    return 3'(N - 1);
`endif
  endfunction

  // Each bench slave answers with its command address xor a per-slave salt; err = addr[3].
  function automatic logic [31:0] salt(input int i);
    return 32'h5A5A_0000 | 32'(i);
  endfunction

  // ---------------- knobs for the bench slaves / master response side ----------------
  logic [N-1:0] knob_rdy = '1;
  logic [N-1:0] knob_rsp_en = '0;
  bit           rdy_rand = 0;
  bit           rsp_rand = 0;
  bit           mrdy_rand = 0;
  logic         knob_mrdy = 1'b0;

  // ---------------- bench slaves ----------------
  logic [31:0] slv_q [N][$];
  bit          pres [N];
  logic [N-1:0] acc_s;
  logic [N-1:0] rhs_s;
  logic [31:0] acc_addr [N];

  always begin
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      acc_s[i]    = sn_cmd_vld[i] && sn_cmd_rdy[i];
      rhs_s[i]    = sn_rsp_vld[i] && sn_rsp_rdy[i];
      acc_addr[i] = sn_cmd_addr[i*AW +: AW];
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        slv_q[i].delete();
        pres[i] = 0;
      end else begin
        if (rhs_s[i]) begin
          void'(slv_q[i].pop_front());
          pres[i] = 0;
        end
        if (acc_s[i]) slv_q[i].push_back(acc_addr[i]);
      end
    end
    #2;
    sn_cmd_rdy = rdy_rand ? N'($urandom) : knob_rdy;
    m_rsp_rdy  = mrdy_rand ? 1'($urandom_range(0, 1)) : knob_mrdy;
    for (int i = 0; i < N; i++) begin
      if (!pres[i] && slv_q[i].size() > 0 && knob_rsp_en[i] &&
          (!rsp_rand || $urandom_range(0, 2) == 0)) pres[i] = 1;
      sn_rsp_vld[i] = pres[i];
      if (pres[i]) begin
        sn_rsp_rdata[i*DW +: DW] = slv_q[i][0] ^ salt(i);
        sn_rsp_err[i]            = slv_q[i][0][3];
      end else begin
        sn_rsp_rdata[i*DW +: DW] = $urandom;
        sn_rsp_err[i]            = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  logic [2:0]  exp_id_q [$];
  logic [31:0] exp_addr_q [$];
  logic [2:0]  c_tgt;
  logic [2:0]  c_head;
  bit          c_full;
  logic [N-1:0] c_sn_vld;
  logic [N-1:0] c_srdy;
  logic        c_cmd_rdy;
  logic        c_vld;
  logic        c_err;
  logic [31:0] c_rdata;
  bit          c_bcast_ok;
  bit          c_push;
  bit          c_pop;
  logic [31:0] c_push_addr;

  always begin
    @(negedge clk);
    if (rst) begin
      exp_id_q.delete();
      exp_addr_q.delete();
    end
    c_tgt    = decode(m_addr);
    c_full   = (exp_id_q.size() == OTS);
    c_sn_vld = '0;
    if (m_vld && !c_full && c_tgt != ERR_ID) c_sn_vld[c_tgt[1:0]] = 1'b1;
    c_cmd_rdy = !c_full && ((c_tgt == ERR_ID) ? 1'b1 : sn_cmd_rdy[c_tgt[1:0]]);
    chk("sn_cmd_vld", 64'(sn_cmd_vld), 64'(c_sn_vld));
    chk("m_cmd_rdy", 64'(m_cmd_rdy), 64'(c_cmd_rdy));
    c_bcast_ok = 1;
    for (int i = 0; i < N; i++) begin
      if (sn_cmd_addr[i*AW +: AW] !== m_addr || sn_cmd_wdata[i*DW +: DW] !== m_wdata ||
          sn_cmd_wstrb[i*SW +: SW] !== m_wstrb || sn_cmd_write[i] !== m_write) c_bcast_ok = 0;
    end
    chk("payload_bcast", 64'(c_bcast_ok), 64'd1);

    c_vld = 1'b0; c_err = 1'b0; c_rdata = '0; c_srdy = '0;
    if (exp_id_q.size() > 0) begin
      c_head = exp_id_q[0];
      if (c_head == ERR_ID) begin
        c_vld = 1'b1;
        c_err = 1'b1;
      end else begin
        c_vld = sn_rsp_vld[c_head[1:0]];
        c_srdy[c_head[1:0]] = m_rsp_rdy;
        if (c_vld) begin
          c_rdata = exp_addr_q[0] ^ salt(int'(c_head));
          c_err   = exp_addr_q[0][3];
        end
      end
    end
    chk("m_rsp_vld", 64'(m_rsp_vld), 64'(c_vld));
    chk("m_rsp_rdata", 64'(m_rsp_rdata), 64'(c_rdata));
    chk("m_rsp_err", 64'(m_rsp_err), 64'(c_err));
    chk("sn_rsp_rdy", 64'(sn_rsp_rdy), 64'(c_srdy));

    c_push      = m_vld && c_cmd_rdy && !rst;
    c_pop       = c_vld && m_rsp_rdy && !rst;
    c_push_addr = m_addr;
    @(posedge clk);
    if (c_pop) begin
      void'(exp_id_q.pop_front());
      void'(exp_addr_q.pop_front());
    end
    if (c_push) begin
      exp_id_q.push_back(c_tgt);
      exp_addr_q.push_back(c_push_addr);
    end
  end

  // ---------------- master driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    m_vld = 1'b1; m_write = w; m_addr = a; m_wdata = d; m_wstrb = s;
  endtask

  task automatic wait_acc(input string name, input int budget);
    bit hs = 0;
    int n = 0;
    while (!hs && n < budget) begin
      @(negedge clk);
      hs = m_cmd_rdy;
      n++;
      tick();
    end
    m_vld = 1'b0;
    chk(name, 64'(hs), 64'd1);
  endtask

  task automatic send(input logic w, input logic [31:0] a, input string name);
    drive_cmd(w, a, $urandom, 4'($urandom));
    wait_acc(name, 50);
  endtask

  task automatic get_rsp(input string name, output logic [31:0] d, output logic e);
    bit got = 0;
    int n = 0;
    d = '0; e = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk);
      if (m_rsp_vld && m_rsp_rdy) begin
        got = 1; d = m_rsp_rdata; e = m_rsp_err;
      end
      n++;
      tick();
    end
    chk(name, 64'(got), 64'd1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    bit idle = 0;
    knob_rsp_en = '1; knob_mrdy = 1'b1; knob_rdy = '1;
    while (!idle && n < 300) begin
      tick();
      idle = (exp_id_q.size() == 0);
      for (int i = 0; i < N; i++) if (slv_q[i].size() != 0) idle = 0;
      n++;
    end
    chk(name, 64'(idle), 64'd1);
    knob_rsp_en = '0; knob_mrdy = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  logic        re;
  bit          hs;
  logic [3:0]  nib [6];

  initial begin
    nib[0] = 4'h0; nib[1] = 4'h1; nib[2] = 4'h2; nib[3] = 4'h3; nib[4] = 4'h8; nib[5] = 4'hE;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_vld", 64'(m_rsp_vld), 64'd0);
    chk("rst_sn_rsp_rdy", 64'(sn_rsp_rdy), 64'd0);
    chk("rst_cmd_rdy_follow_hi", 64'(m_cmd_rdy), 64'd1);
    knob_rdy = '0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_cmd_rdy_follow_lo", 64'(m_cmd_rdy), 64'd0);
    knob_rdy = '1;
    tick();
    tick();
    rst = 1'b0;

    // write into slave1's window: only port 1 strobed, payload untouched
    drive_cmd(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hC);
    @(negedge clk);
    chk("b_sn_vld", 64'(sn_cmd_vld), 64'h2);
    chk("b_wdata", 64'(sn_cmd_wdata[DW +: DW]), 64'hDEAD_BEEF);
    chk("b_wstrb", 64'(sn_cmd_wstrb[SW +: SW]), 64'hC);
    chk("b_addr", 64'(sn_cmd_addr[AW +: AW]), 64'h1000_0004);
    chk("b_write", 64'(sn_cmd_write[1]), 64'd1);
    hs = m_cmd_rdy;
    tick();
    m_vld = 1'b0;
    chk("b_accept", 64'(hs), 64'd1);
    @(negedge clk);
    chk("b_no_rsp_yet", 64'(m_rsp_vld), 64'd0);
    drain("b_drain");

    // two outstanding fill the FIFO; the third waits for a pop
    send(1'b0, 32'h0000_0010, "c_acc0");
    send(1'b0, 32'h2000_0020, "c_acc1");
    drive_cmd(1'b0, 32'h3000_0030, 32'h0, 4'h0);
    repeat (3) begin
      @(negedge clk);
      chk("c_full_rdy", 64'(m_cmd_rdy), 64'd0);
      chk("c_full_vld", 64'(sn_cmd_vld), 64'd0);
      tick();
    end
    knob_mrdy = 1'b1; knob_rsp_en = '1;
    wait_acc("c_acc2", 20);
    drain("c_drain");

    // slave1 answers first but must wait behind slave0
    knob_mrdy = 1'b1;
    send(1'b0, 32'h0000_0100, "d_accA");
    send(1'b0, 32'h1000_0200, "d_accB");
    knob_rsp_en = 4'b0010;
    repeat (3) tick();
    @(negedge clk);
    chk("d_s1_presented", 64'(sn_rsp_vld[1]), 64'd1);
    chk("d_s1_stalled", 64'(sn_rsp_rdy[1]), 64'd0);
    chk("d_m_vld_low", 64'(m_rsp_vld), 64'd0);
    tick();
    knob_rsp_en = 4'b0011;
    get_rsp("d_rspA_seen", rd, re);
    chk("d_first_A", 64'(rd), 64'h5A5A_0100);
    get_rsp("d_rspB_seen", rd, re);
    chk("d_second_B", 64'(rd), 64'h4A5A_0201);
    drain("d_drain");

    // master back-pressure holds the response
    knob_mrdy = 1'b0; knob_rsp_en = '1;
    send(1'b0, 32'h2000_0008, "e_acc");
    for (int n = 0; n < 20 && !m_rsp_vld; n++) tick();
    repeat (5) begin
      @(negedge clk);
      chk("e_hold_vld", 64'(m_rsp_vld), 64'd1);
      chk("e_hold_data", 64'(m_rsp_rdata), 64'h7A5A_000A);
      chk("e_hold_err", 64'(m_rsp_err), 64'd1);
      tick();
    end
    drain("e_drain");

    // decode: overlap priority and unmapped address
    knob_rdy = '0;
    tick();
    drive_cmd(1'b0, 32'h2000_0040, 32'h0, 4'h0);
    @(negedge clk);
    chk("f_overlap_lo", 64'(sn_cmd_vld), 64'h4);
    tick();
    m_addr = 32'h3000_0040;
    @(negedge clk);
    chk("f_overlap_hi", 64'(sn_cmd_vld), 64'h8);
    tick();
    m_addr = 32'hE000_0000;
    @(negedge clk);
`ifdef LNRV_ICB_SPLT_DEC_ERR_EN
    chk("f_unmapped_no_vld", 64'(sn_cmd_vld), 64'h0);
    chk("f_unmapped_rdy", 64'(m_cmd_rdy), 64'd1);
    tick();
    m_vld = 1'b0;
    @(negedge clk);
    chk("f_err_vld", 64'(m_rsp_vld), 64'd1);
    chk("f_err_err", 64'(m_rsp_err), 64'd1);
    chk("f_err_rdata", 64'(m_rsp_rdata), 64'h0);
`else
    chk("f_default_slave", 64'(sn_cmd_vld), 64'h8);
    tick();
    m_vld = 1'b0;
`endif
    drain("f_drain");

    // reset with two outstanding commands
    send(1'b0, 32'h0000_0300, "g_accA");
    send(1'b0, 32'h1000_0300, "g_accB");
    rst = 1'b1;
    @(negedge clk);
    chk("g_rst_vld", 64'(m_rsp_vld), 64'd0);
    chk("g_rst_srdy", 64'(sn_rsp_rdy), 64'd0);
    tick();
    rst = 1'b0;
    knob_rsp_en = '1; knob_mrdy = 1'b1;
    send(1'b0, 32'h1000_0300, "g_new_acc");
    get_rsp("g_new_rsp_seen", rd, re);
    chk("g_new_rsp", 64'(rd), 64'h4A5A_0301);
    drain("g_drain");

    // randomized traffic
    rdy_rand = 1; mrdy_rand = 1; rsp_rand = 1; knob_rsp_en = '1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      hs = m_vld && m_cmd_rdy;
      tick();
      if (!m_vld || hs) begin
        if ($urandom_range(0, 2) != 0)
          drive_cmd(1'($urandom_range(0, 1)),
                    {nib[$urandom_range(0, 5)], 28'($urandom)}, $urandom, 4'($urandom));
        else
          m_vld = 1'b0;
      end
    end
    m_vld = 1'b0;
    rdy_rand = 0; mrdy_rand = 0; rsp_rand = 0;
    drain("h_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
